// File: rtl/c1541_track_engine.sv
// 1541 track engine: streams a buffered track past a virtual head at zone bit rate,
// framing SYNC/bytes for the VIA in read mode and writing VIA bytes back in write mode.
module c1541_track_engine (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        mtr,
  input  logic [1:0]  freq,
  input  logic        mode,
  input  logic [7:0]  dout,
  input  logic        wps_n,
  input  logic [12:0] track_len,
  output logic [12:0] ram_addr,
  input  logic [7:0]  ram_do,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  output logic [7:0]  din,
  output logic        sync_n,
  output logic        byte_n
);

  logic [7:0]  tick_cnt;
  logic [7:0]  per;
  logic [12:0] pos;
  logic [2:0]  bit_idx;
  logic [7:0]  tx_byte;
  logic        ld_d1;
  logic        ld_d2;
  logic        mtr_q;
  logic [9:0]  rx_sr;
  logic [2:0]  rx_cnt;
  logic [5:0]  bn_cnt;
  logic [7:0]  wr_latch;
  logic        wr_valid;

  logic [4:0]  zone_mul;
  logic [7:0]  period_next;
  logic        tick;
  logic        has_track;
  logic        boundary;
  logic        tx_bit;
  logic [9:0]  rx_next;
  logic        rx_sync;
  logic        rx_wrap;
  logic        wr_boundary;
  logic        pulse;

  assign zone_mul    = 5'd16 - {3'b000, freq};
  assign period_next = {zone_mul, 3'b000};
  assign tick        = mtr && (tick_cnt == per - 8'd1);
  assign has_track   = (track_len != 13'd0);
  assign boundary    = tick && (bit_idx == 3'd7) && has_track;
  assign tx_bit      = tx_byte[3'd7 - bit_idx];
  assign rx_next     = {rx_sr[8:0], tx_bit};
  assign rx_sync     = &rx_next;
  assign rx_wrap     = tick && mode && !rx_sync && (rx_cnt == 3'd7);
  assign wr_boundary = boundary && !mode;
  assign pulse       = (rx_wrap && has_track) || wr_boundary;

  // The write strobe must coincide with the pre-advance address, so it is
  // decoded from the boundary tick itself rather than registered.
  assign ram_we   = reset_n && wr_boundary && wr_valid && wps_n && mtr;
  assign ram_addr = pos;
  assign ram_di   = wr_latch;

  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      tick_cnt <= 8'd0;
      per      <= period_next;
      pos      <= 13'd0;
      bit_idx  <= 3'd0;
      tx_byte  <= 8'd0;
      ld_d1    <= 1'b1;
      ld_d2    <= 1'b0;
      mtr_q    <= 1'b0;
      rx_sr    <= 10'd0;
      rx_cnt   <= 3'd0;
      bn_cnt   <= 6'd0;
      wr_latch <= 8'd0;
      wr_valid <= 1'b0;
      din      <= 8'd0;
      sync_n   <= 1'b1;
      byte_n   <= 1'b1;
    end else begin
      mtr_q <= mtr;
      // RAM read is registered: address settles one cycle, data the next.
      ld_d1 <= boundary || (mtr && !mtr_q);
      ld_d2 <= ld_d1;
      if (ld_d2) tx_byte <= ram_do;

      if (!mtr || tick) begin
        tick_cnt <= 8'd0;
        per      <= period_next;
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
      end

      if (!has_track) begin
        pos <= 13'd0;
      end else if (boundary) begin
        pos <= (pos == track_len - 13'd1) ? 13'd0 : pos + 13'd1;
      end

      if (tick) begin
        bit_idx <= bit_idx + 3'd1;
        if (mode) begin
          rx_sr  <= rx_next;
          sync_n <= !rx_sync;
          rx_cnt <= rx_sync ? 3'd0 : rx_cnt + 3'd1;
          if (rx_wrap) din <= rx_next[7:0];
        end else begin
          rx_sr  <= 10'd0;
          rx_cnt <= 3'd0;
          sync_n <= 1'b1;
        end
      end

      if (wr_boundary) wr_latch <= dout;
      if (mode) wr_valid <= 1'b0;
      else if (boundary) wr_valid <= 1'b1;

      // A fresh pulse always restarts the 40-cycle low window.
      if (!mtr) begin
        byte_n <= 1'b1;
        bn_cnt <= 6'd0;
        sync_n <= 1'b1;
      end else if (pulse) begin
        byte_n <= 1'b0;
        bn_cnt <= 6'd39;
      end else if (!byte_n) begin
        if (bn_cnt == 6'd0) byte_n <= 1'b1;
        else bn_cnt <= bn_cnt - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_c1541_track_engine.sv
// Bench for c1541_track_engine: zone table, hand-built corner sequences and
// random tracks checked against a bit-stream level model.
module tb_c1541_track_engine;

  logic        clk32;
  logic        reset_n;
  logic        mtr;
  logic [1:0]  freq;
  logic        mode;
  logic [7:0]  dout;
  logic        wps_n;
  logic [12:0] track_len;
  logic [12:0] ram_addr;
  logic [7:0]  ram_do;
  logic [7:0]  ram_di;
  logic        ram_we;
  logic [7:0]  din;
  logic        sync_n;
  logic        byte_n;

  c1541_track_engine dut (
    .clk32     (clk32),
    .reset_n   (reset_n),
    .mtr       (mtr),
    .freq      (freq),
    .mode      (mode),
    .dout      (dout),
    .wps_n     (wps_n),
    .track_len (track_len),
    .ram_addr  (ram_addr),
    .ram_do    (ram_do),
    .ram_di    (ram_di),
    .ram_we    (ram_we),
    .din       (din),
    .sync_n    (sync_n),
    .byte_n    (byte_n)
  );

  // clock / reset block
  initial clk32 = 1'b0;
  always #8 clk32 = ~clk32;

  logic [7:0] mem [0:8191];
  always @(posedge clk32) ram_do <= mem[ram_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [20:0] exp_q[$];
  int          we_step[$];
  logic        prev_we = 1'b0;

  logic [7:0] trk [0:15];
  int         trk_len;

  typedef struct {
    logic [1:0]  freq;
    logic [12:0] len;
    int          exp_bound;
    logic [12:0] addr1;
    logic [12:0] addr2;
  } zone_vec_t;
  zone_vec_t zv [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk32);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic load_track();
    for (int i = 0; i < trk_len; i++) mem[i] = trk[i];
  endtask

  task automatic wait_addr_change(input int limit, output int n, output logic saw_sync);
    logic [12:0] old;
    old = ram_addr;
    n = -1;
    saw_sync = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (sync_n === 1'b0) saw_sync = 1'b1;
      if (ram_addr !== old) begin
        n = k;
        break;
      end
    end
  endtask

  // scoreboard for track-buffer writes
  always @(negedge clk32) begin
    if (ram_we === 1'b1) begin
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
      we_step.push_back(cyc);
      if (exp_q.size() == 0) chk("we_unexpected", {31'd0, ram_we}, 32'd0);
      else chk("we_addr_data", {11'd0, ram_addr, ram_di}, {11'd0, exp_q.pop_front()});
    end
    prev_we = (ram_we === 1'b1);
  end

  // Stream bit n (1-based) of the circular track, MSB first.
  function automatic logic sbit(input int n);
    int b;
    int k;
    b = ((n - 1) / 8) % trk_len;
    k = (n - 1) % 8;
    return trk[b][7 - k];
  endfunction

  task automatic run_random();
    int         per;
    int         t;
    int         last_sync;
    logic       s;
    logic [7:0] d;
    logic [7:0] din_cur;
    logic       sync_a  [0:64];
    logic       pulse_a [0:64];
    logic [7:0] din_a   [0:64];
    freq    = 2'($urandom_range(0, 3));
    per     = 8 * (16 - int'(freq));
    trk_len = int'($urandom_range(2, 9));
    for (int i = 0; i < trk_len; i++) trk[i] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
    load_track();
    track_len = 13'(trk_len);
    mode = 1'b1;
    mtr = 1'b1;
    wps_n = 1'b1;
    // Model: SYNC is ten ones in the received stream; bytes are framed every
    // eighth non-SYNC bit counted from the last SYNC bit (or from reset).
    sync_a[0] = 1'b0;
    pulse_a[0] = 1'b0;
    din_a[0] = 8'h00;
    din_cur = 8'h00;
    last_sync = 0;
    for (int n = 1; n <= 64; n++) begin
      s = (n >= 10);
      for (int j = 0; j < 10; j++) if (n - j >= 1) s = s & sbit(n - j);
      sync_a[n] = s;
      pulse_a[n] = 1'b0;
      if (s) last_sync = n;
      else if ((n - last_sync) % 8 == 0) begin
        for (int j = 0; j < 8; j++) d[j] = sbit(n - j);
        din_cur = d;
        pulse_a[n] = 1'b1;
      end
      din_a[n] = din_cur;
    end
    do_reset();
    for (int e = 1; e <= 64 * per; e++) begin
      step();
      t = e / per;
      chk("rnd_addr", 32'(ram_addr), 32'((t / 8) % trk_len));
      chk("rnd_sync_n", {31'd0, sync_n}, (t == 0) ? 32'd1 : (sync_a[t] ? 32'd0 : 32'd1));
      chk("rnd_din", 32'(din), 32'(din_a[t]));
      chk("rnd_byte_n", {31'd0, byte_n}, (pulse_a[t] && (e - t * per) < 40) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic run_write(input logic wp);
    track_len = 13'd8;
    freq = 2'd3;
    mode = 1'b0;
    mtr = 1'b1;
    wps_n = wp;
    dout = 8'hA5;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    we_step.delete();
    exp_q.delete();
    if (wp) begin
      exp_q.push_back({13'd1, 8'hA5});
      exp_q.push_back({13'd2, 8'h3C});
    end
    do_reset();
    for (int k = 1; k <= 2600; k++) begin
      step();
      if (k == 831) chk("wr_byte_n_before", {31'd0, byte_n}, 32'd1);
      if (k == 832) chk("wr_byte_n_pulse", {31'd0, byte_n}, 32'd0);
      if (k == 900) dout = 8'h3C;
    end
    chk("wr_pending", 32'(exp_q.size()), 32'd0);
    chk("wr_count", 32'(we_step.size()), wp ? 32'd2 : 32'd0);
    if (we_step.size() == 2) begin
      chk("wr_cycle1", 32'(we_step[0]), 32'd1663);
      chk("wr_cycle2", 32'(we_step[1]), 32'd2495);
    end
    mode = 1'b1;
    wps_n = 1'b1;
  endtask

  int         n;
  int         n2;
  logic       saw;
  int         fall;
  int         rise;
  int         bfall;
  int         brise;
  logic [7:0] dsamp;

  initial begin
    zv[0] = '{2'd3, 13'd5, 832, 13'd1, 13'd2};
    zv[1] = '{2'd0, 13'd2, 1024, 13'd1, 13'd0};
    zv[2] = '{2'd1, 13'd3, 960, 13'd1, 13'd2};
    zv[3] = '{2'd2, 13'd2, 896, 13'd1, 13'd0};

    reset_n = 1'b0;
    mtr = 1'b0;
    freq = 2'd0;
    mode = 1'b1;
    dout = 8'h00;
    wps_n = 1'b1;
    track_len = 13'd4;
    for (int i = 0; i < 16; i++) mem[i] = 8'h55;

    // reset state
    do_reset();
    chk("rst_din", 32'(din), 32'h00);
    chk("rst_sync_n", {31'd0, sync_n}, 32'd1);
    chk("rst_byte_n", {31'd0, byte_n}, 32'd1);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_di", 32'(ram_di), 32'h00);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);

    // zone table: boundary spacing and address progression
    for (int i = 0; i < 4; i++) begin
      freq = zv[i].freq;
      track_len = zv[i].len;
      mode = 1'b1;
      mtr = 1'b1;
      do_reset();
      wait_addr_change(3000, n, saw);
      chk("zone_first_bound", 32'(n), 32'(zv[i].exp_bound));
      chk("zone_addr1", 32'(ram_addr), 32'(zv[i].addr1));
      wait_addr_change(3000, n2, saw);
      chk("zone_bound_period", 32'(n2), 32'(zv[i].exp_bound));
      chk("zone_addr2", 32'(ram_addr), 32'(zv[i].addr2));
      chk("zone_no_sync", {31'd0, saw}, 32'd0);
    end

    // wrap: 0,1,2,3,4,0
    freq = 2'd3;
    track_len = 13'd5;
    do_reset();
    for (int j = 1; j <= 5; j++) begin
      wait_addr_change(1000, n, saw);
      chk("wrap_addr", 32'(ram_addr), 32'(j % 5));
    end

    // SYNC detection and post-SYNC framing
    trk_len = 6;
    trk[0] = 8'hFF; trk[1] = 8'hFF; trk[2] = 8'h52;
    trk[3] = 8'h55; trk[4] = 8'h55; trk[5] = 8'h55;
    load_track();
    track_len = 13'd6;
    freq = 2'd3;
    do_reset();
    fall = -1; rise = -1; bfall = -1; brise = -1; dsamp = 8'h00;
    for (int k = 1; k <= 2700; k++) begin
      step();
      if (fall < 0 && sync_n == 1'b0) fall = k;
      else if (fall >= 0 && rise < 0 && sync_n == 1'b1) rise = k;
      else if (rise >= 0 && bfall < 0 && byte_n == 1'b0) begin
        bfall = k;
        dsamp = din;
      end else if (bfall >= 0 && brise < 0 && byte_n == 1'b1) brise = k;
    end
    chk("sync_fall", 32'(fall), 32'd1040);
    chk("sync_rise", 32'(rise), 32'd1768);
    chk("sync_byte_fall", 32'(bfall), 32'd2496);
    chk("sync_byte_len", 32'(brise - bfall), 32'd40);
    chk("sync_din", 32'(dsamp), 32'h52);

    // write path, unprotected then protected
    run_write(1'b1);
    run_write(1'b0);

    // motor off mid-byte
    for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
    track_len = 13'd4;
    freq = 2'd2;
    mode = 1'b1;
    mtr = 1'b1;
    do_reset();
    for (int k = 1; k <= 1282; k++) step();
    chk("mot_pre_addr", 32'(ram_addr), 32'd1);
    chk("mot_pre_sync", {31'd0, sync_n}, 32'd0);
    mtr = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      chk("mot_off_addr", 32'(ram_addr), 32'd1);
      chk("mot_off_byte_n", {31'd0, byte_n}, 32'd1);
      chk("mot_off_sync_n", {31'd0, sync_n}, 32'd1);
    end
    mtr = 1'b1;
    wait_addr_change(1000, n, saw);
    chk("mot_resume_bound", 32'(n), 32'd560);
    chk("mot_resume_addr", 32'(ram_addr), 32'd2);

    // reset in the middle of a byte_n pulse
    for (int i = 0; i < 8; i++) mem[i] = 8'h55;
    freq = 2'd3;
    do_reset();
    n = -1;
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (byte_n == 1'b0) begin
        n = k;
        break;
      end
    end
    chk("rp_pulse_at", 32'(n), 32'd832);
    for (int k = 0; k < 10; k++) step();
    chk("rp_pre_din", 32'(din), 32'h55);
    chk("rp_pre_addr", 32'(ram_addr), 32'd1);
    reset_n = 1'b0;
    step();
    chk("rp_byte_n", {31'd0, byte_n}, 32'd1);
    chk("rp_din", 32'(din), 32'h00);
    chk("rp_addr", 32'(ram_addr), 32'd0);
    chk("rp_sync_n", {31'd0, sync_n}, 32'd1);
    chk("rp_ram_we", {31'd0, ram_we}, 32'd0);
    reset_n = 1'b1;

    // empty track: no boundaries, no byte_n
    track_len = 13'd0;
    do_reset();
    for (int k = 1; k <= 2100; k++) begin
      step();
      chk("empty_byte_n", {31'd0, byte_n}, 32'd1);
      chk("empty_addr", 32'(ram_addr), 32'd0);
    end

    // random tracks against the stream model
    for (int r = 0; r < 4; r++) run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c1541_track_engine.md
C1541_TRACK_ENGINE -- requirements
Module: c1541_track_engine

Interface
REQ-001 SHALL have port clk32, input, 1 bit: sole clock, 32 MHz.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on the clk32 rising edge.
REQ-003 SHALL have port mtr, input, 1 bit: spindle motor on (1).
REQ-004 SHALL have port freq, input, 2 bits: density zone 0..3.
REQ-005 SHALL have port mode, input, 1 bit: 1 = read, 0 = write.
REQ-006 SHALL have port dout, input, 8 bits: write byte from the drive VIA.
REQ-007 SHALL have port wps_n, input, 1 bit: write-protect sense (0 = protected).
REQ-008 SHALL have port track_len, input, 13 bits: bytes in the current track.
REQ-009 SHALL have port ram_addr, output, 13 bits: track-buffer byte address.
REQ-010 SHALL have port ram_do, input, 8 bits: track-buffer read data, 1-cycle registered.
REQ-011 SHALL have port ram_di, output, 8 bits: track-buffer write data.
REQ-012 SHALL have port ram_we, output, 1 bit: track-buffer write strobe.
REQ-013 SHALL have port din, output, 8 bits: byte read from disk, to the VIA.
REQ-014 SHALL have port sync_n, output, 1 bit: SYNC detected (0).
REQ-015 SHALL have port byte_n, output, 1 bit: byte ready (0).

Function
REQ-016 SHALL generate bit ticks every 8*(16-freq) clk32 cycles (zone 3 = 104 cycles); freq is sampled at each tick to set the next period.
REQ-017 SHALL stop ticking while mtr=0, freezing pos, bit_idx and rx state; byte_n SHALL be 1 and sync_n SHALL be 1.
REQ-018 SHALL keep a byte position pos (13 bits) and a bit index bit_idx (0..7); ram_addr SHALL equal pos combinationally.
REQ-019 On each tick, the emitted bit SHALL be tx_byte[7-bit_idx] (MSB first), and bit_idx SHALL increment.
REQ-020 On the tick with bit_idx=7 (byte boundary), bit_idx SHALL become 0 and pos SHALL advance: pos = (pos = track_len-1) ? 0 : pos+1.
REQ-021 If track_len=0, pos SHALL be held at 0, no boundary actions SHALL occur, and byte_n SHALL stay 1.
REQ-022 tx_byte SHALL load from ram_do exactly 2 cycles after each boundary, and 2 cycles after reset or motor-on.
REQ-023 Read mode (mode=1): each emitted bit SHALL shift into a 10-bit rx_sr, LSB in.
REQ-024 sync_n SHALL be updated per tick: 0 if mode=1 and rx_sr (after the shift) is all ones, else 1.
REQ-025 While sync_n=0, rx_cnt (3 bits) SHALL be held at 0. Otherwise each tick SHALL increment rx_cnt. On the wrap 7->0, din <= rx_sr[7:0] and byte_n is pulsed.
REQ-026 Each byte_n pulse SHALL be exactly 40 clk32 cycles low; a new pulse during an active pulse SHALL restart the 40-cycle count.
REQ-027 Write mode (mode=0): on each boundary, byte_n SHALL pulse and wr_latch <= dout.
REQ-028 In write mode, on a boundary where wr_valid=1, wps_n=1 and mtr=1, ram_we SHALL be 1 for that single cycle, with ram_di=wr_latch and ram_addr=pos before the advance.
REQ-029 wr_valid SHALL be set by the first write-mode boundary and cleared when mode=1. The first boundary after entering write mode therefore writes nothing.
REQ-030 In write mode, rx_sr SHALL be cleared, rx_cnt SHALL be 0, sync_n SHALL be 1, and din SHALL hold its value.
REQ-031 A mode change SHALL take effect at the next tick; a boundary and a byte_n restart in the same cycle SHALL both occur.

Reset
REQ-032 On reset_n=0 at a clk32 edge, the following SHALL be cleared: pos=0, bit_idx=0, tick counter=0, rx_sr=0, rx_cnt=0, tx_byte=0, wr_latch=0 and wr_valid=0.
REQ-033 During reset, outputs SHALL be: din=0x00, sync_n=1, byte_n=1, ram_we=0, ram_di=0x00.
REQ-034 A reset asserted mid-byte or mid-pulse SHALL abort both, with no ram_we.

Verification
REQ-035 Zone check: freq=3, mtr=1, mode=1, track of 0x55 bytes -> a tick every 104 cycles, a boundary every 832 cycles, sync_n=1 throughout.
REQ-036 SYNC check: track of FF FF 52 ..., mode=1 -> sync_n=0 from the 10th one-bit tick, rising on the first 0 bit. The first byte_n pulse (40 cycles low) comes 8 ticks after sync ends, with din=0x52 as framed post-sync.
REQ-037 Wrap check: track_len=5, mtr=1 -> ram_addr sequence 0,1,2,3,4,0.
REQ-038 Write check: mode=0, wps_n=1, dout=0xA5 at boundary k -> ram_we single cycle at boundary k+1, ram_di=0xA5, ram_addr=the pos before the advance. The same test with wps_n=0 -> no ram_we.
REQ-039 Motor off mid-byte: mtr=0 for 1000 cycles -> pos and bit_idx frozen, byte_n=1, sync_n=1. On resume, the next tick comes 8*(16-freq) cycles after mtr=1.
REQ-040 Reset during a byte_n pulse -> byte_n=1, din=0x00, pos=0 on the next edge.
